// File: rtl/arilla_pkg.sv
// Shared types, constants and helpers for arilla bus endpoints and the interconnect.
package arilla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arilla_target_state_e;

  // Read data returned when a local peripheral never answers.
  localparam logic [31:0] ARILLA_ERROR_PATTERN = 32'hBADC_0FFE;

  function automatic logic [31:0] arilla_word_addr(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/arilla_window_decode.sv
// Word-address window hit compare; shared by bus targets and the interconnect.
module arilla_window_decode #(
  parameter int                      DataWidth    = 32,
  parameter int                      AddressWidth = 32,
  parameter logic [AddressWidth-1:0] BaseAddress  = 32'h1000_0000,
  parameter int                      WindowWords  = 16,
  localparam int                     ByteBits      = $clog2(DataWidth / 8),
  localparam int                     WordAddrWidth = AddressWidth - ByteBits,
  localparam int                     OffsetBits    = $clog2(WindowWords)
) (
  input  logic [WordAddrWidth-1:0] i_word_addr,
  output logic                     o_hit
);

  localparam logic [AddressWidth-1:0] BaseWord = BaseAddress >> ByteBits;

  // The base is window-aligned, so only the bits above the offset take part.
  assign o_hit = (i_word_addr[WordAddrWidth-1:OffsetBits] == BaseWord[WordAddrWidth-1:OffsetBits]);

endmodule

// File: rtl/arilla_bus_target.sv
// Arilla bus responder: claims a fixed window and forwards it to a req/ack local port.
// Optional WAIT timeout with error read data is enabled by ARILLA_TARGET_TIMEOUT_EN.
module arilla_bus_target
  import arilla_pkg::*;
#(
  parameter int                      DataWidth     = 32,
  parameter int                      AddressWidth  = 32,
  parameter logic [AddressWidth-1:0] BaseAddress   = 32'h1000_0000,
  parameter int                      WindowWords   = 16,
  parameter int                      TimeoutCycles = 15,
  localparam int                     ByteBits      = $clog2(DataWidth / 8),
  localparam int                     WordAddrWidth = AddressWidth - ByteBits,
  localparam int                     OffsetBits    = $clog2(WindowWords),
  localparam int                     StrbWidth     = DataWidth / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WordAddrWidth-1:0] bus_address,
  input  logic [DataWidth-1:0]     bus_wdata,
  input  logic [StrbWidth-1:0]     bus_byte_enable,
  input  logic                     bus_read,
  input  logic                     bus_write,
  output logic [DataWidth-1:0]     bus_rdata,
  output logic                     bus_available,
  output logic                     bus_intercept,
  output logic                     loc_req,
  output logic                     loc_write,
  output logic [OffsetBits-1:0]    loc_addr,
  output logic [DataWidth-1:0]     loc_wdata,
  output logic [StrbWidth-1:0]     loc_byte_enable,
  input  logic                     loc_ack,
  input  logic [DataWidth-1:0]     loc_rdata
);

  arilla_target_state_e   r_state;
  logic                   r_loc_req;
  logic                   r_loc_write;
  logic [OffsetBits-1:0]  r_loc_addr;
  logic [DataWidth-1:0]   r_loc_wdata;
  logic [StrbWidth-1:0]   r_loc_be;
  logic                   r_bus_available;
  logic [DataWidth-1:0]   r_bus_rdata;
  logic                   w_hit;
  logic                   w_expired;
  logic [DataWidth-1:0]   w_done_rdata;

  arilla_window_decode #(
    .DataWidth   (DataWidth),
    .AddressWidth(AddressWidth),
    .BaseAddress (BaseAddress),
    .WindowWords (WindowWords)
  ) u_decode (
    .i_word_addr(bus_address),
    .o_hit      (w_hit)
  );

  assign bus_intercept = w_hit & (bus_read | bus_write);

`ifdef ARILLA_TARGET_TIMEOUT_EN
  localparam int                    CntWidth = $clog2(TimeoutCycles + 1);
  localparam int                    ErrReps  = (DataWidth + 31) / 32;
  localparam logic [ErrReps*32-1:0] ErrWide  = {ErrReps{ARILLA_ERROR_PATTERN}};
  localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] r_wait_cnt;

  // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_expired    = (r_wait_cnt == CntLast);
  assign w_done_rdata = r_loc_write ? '0 : (loc_ack ? loc_rdata : ErrWide[DataWidth-1:0]);
`else
  assign w_expired    = 1'b0;
  assign w_done_rdata = r_loc_write ? '0 : loc_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_loc_req       <= 1'b0;
      r_loc_write     <= 1'b0;
      r_loc_addr      <= '0;
      r_loc_wdata     <= '0;
      r_loc_be        <= '0;
      r_bus_available <= 1'b0;
      r_bus_rdata     <= '0;
    end else begin
      r_bus_available <= 1'b0;
      r_bus_rdata     <= '0;
      case (r_state)
        IDLE: begin
          if (bus_intercept) begin
            r_loc_req   <= 1'b1;
            r_loc_write <= bus_write;
            r_loc_addr  <= bus_address[OffsetBits-1:0];
            r_loc_wdata <= bus_wdata;
            r_loc_be    <= bus_byte_enable;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (loc_ack || w_expired) begin
            r_loc_req       <= 1'b0;
            r_bus_available <= 1'b1;
            r_bus_rdata     <= w_done_rdata;
            r_state         <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign loc_req         = r_loc_req;
  assign loc_write       = r_loc_write;
  assign loc_addr        = r_loc_addr;
  assign loc_wdata       = r_loc_wdata;
  assign loc_byte_enable = r_loc_be;
  assign bus_available   = r_bus_available;
  assign bus_rdata       = r_bus_rdata;

endmodule

// File: tb/tb_arilla_bus_target.sv
// Bench for arilla_bus_target: per-cycle expectations from a transaction-level model.
module tb_arilla_bus_target;

  localparam int          TC     = 15;
  localparam logic [29:0] BASE_W = 30'h0400_0000;
  localparam int          MAXC   = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] bus_address = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_byte_enable = '0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_available;
  logic        bus_intercept;
  logic        loc_req;
  logic        loc_write;
  logic [3:0]  loc_addr;
  logic [31:0] loc_wdata;
  logic [3:0]  loc_byte_enable;
  logic        loc_ack;
  logic [31:0] loc_rdata = '0;

  always #5 clk = ~clk;

  arilla_bus_target dut (
    .clk(clk), .rst_n(rst_n),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_available(bus_available), .bus_intercept(bus_intercept),
    .loc_req(loc_req), .loc_write(loc_write), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_byte_enable(loc_byte_enable), .loc_ack(loc_ack), .loc_rdata(loc_rdata)
  );

  // Local responder: acks after ack_delay cycles of loc_req; stray acks only while idle.
  int unsigned ack_delay = 0;
  logic        stray_ack = 1'b0;
  int unsigned req_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                req_cnt <= 0;
    else if (loc_req && !loc_ack) req_cnt <= req_cnt + 1;
    else                       req_cnt <= 0;
  end
  assign loc_ack = (loc_req && (req_cnt >= ack_delay)) || (stray_ack && !loc_req);

  typedef struct packed {
    logic        icpt;
    logic        req;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        avail;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q [MAXC];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_avail = 0;
  int   last_avail_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic check_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus_available) begin
      n_avail++;
      last_avail_cyc = cyc;
      last_rdata = bus_rdata;
    end
    if (check_en && cyc < MAXC) begin
      chk("intercept", 32'(bus_intercept), 32'(exp_q[cyc].icpt));
      chk("loc_req", 32'(loc_req), 32'(exp_q[cyc].req));
      chk("bus_available", 32'(bus_available), 32'(exp_q[cyc].avail));
      chk("bus_rdata", bus_rdata, exp_q[cyc].rdata);
      if (exp_q[cyc].req) begin
        chk("loc_write", 32'(loc_write), 32'(exp_q[cyc].wr));
        chk("loc_addr", 32'(loc_addr), 32'(exp_q[cyc].addr));
        chk("loc_wdata", loc_wdata, exp_q[cyc].wdata);
        chk("loc_byte_enable", 32'(loc_byte_enable), 32'(exp_q[cyc].be));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One hit transaction starting this cycle; returns after the cycle following completion.
  task automatic run_txn(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input int d,
                         input logic [31:0] rdat, output int s0);
    int   s;
    int   w;
    logic to;
    s  = cyc;
    w  = d + 1;
    to = 1'b0;
`ifdef ARILLA_TARGET_TIMEOUT_EN
    if (d + 1 > TC) begin
      w  = TC;
      to = 1'b1;
    end
`endif
    for (int k = 0; k <= w + 1; k++) begin
      exp_t e;
      e = '0;
      e.icpt = 1'b1;
      if (k >= 1 && k <= w) begin
        e.req   = 1'b1;
        e.wr    = wr;
        e.addr  = 4'(addr - BASE_W);
        e.wdata = wd;
        e.be    = be;
      end
      if (k == w + 1) begin
        e.avail = 1'b1;
        e.rdata = wr ? 32'h0 : (to ? 32'hBADC_0FFE : rdat);
      end
      if (s + k < MAXC) exp_q[s + k] = e;
    end
    ack_delay       = d;
    loc_rdata       = rdat;
    bus_address     = addr;
    bus_wdata       = wd;
    bus_byte_enable = be;
    bus_read        = rd;
    bus_write       = wr;
    repeat (w + 2) next_cycle();
    s0 = s;
  endtask

  // stray: 0 none, 1 random, 2 always.
  task automatic idle(input int n, input logic miss_strobe, input logic [29:0] miss_addr,
                      input int stray);
    bus_read    = miss_strobe;
    bus_write   = 1'b0;
    bus_address = miss_addr;
    for (int k = 0; k < n; k++) begin
      if (cyc < MAXC) exp_q[cyc] = '0;
      stray_ack = (stray == 2) ? 1'b1 : (stray == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      next_cycle();
    end
    stray_ack = 1'b0;
  endtask

  function automatic logic [29:0] rand_miss();
    if ($urandom_range(0, 1) == 1) return BASE_W + 30'd16 + 30'($urandom_range(0, 999));
    else                           return BASE_W - 30'd1 - 30'($urandom_range(0, 999));
  endfunction

  initial begin
    int s0;
    int n0;
    logic rd;
    logic wr;
    int kind;
    for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
    check_en = 1'b1;

    next_cycle();
    next_cycle();
    chk("rst_loc_req", 32'(loc_req), 32'h0);
    chk("rst_loc_write", 32'(loc_write), 32'h0);
    chk("rst_loc_addr", 32'(loc_addr), 32'h0);
    chk("rst_loc_wdata", loc_wdata, 32'h0);
    chk("rst_loc_be", 32'(loc_byte_enable), 32'h0);
    chk("rst_avail", 32'(bus_available), 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    rst_n = 1'b1;
    idle(2, 1'b0, '0, 0);

    run_txn(1'b1, 1'b0, 30'h0400_0003, 32'h0, 4'hF, 0, 32'hCAFE_F00D, s0);
    chk("rd0_latency", 32'(last_avail_cyc - s0), 32'd2);
    chk("rd0_rdata", last_rdata, 32'hCAFE_F00D);
    chk("rd0_loc_addr", 32'(loc_addr), 32'd3);
    idle(2, 1'b0, '0, 0);

    run_txn(1'b0, 1'b1, BASE_W + 30'd5, 32'h1234_5678, 4'b0110, 3, 32'hFFFF_FFFF, s0);
    chk("wr3_latency", 32'(last_avail_cyc - s0), 32'd5);
    chk("wr3_rdata", last_rdata, 32'h0);
    chk("wr3_loc_wdata", loc_wdata, 32'h1234_5678);
    chk("wr3_loc_be", 32'(loc_byte_enable), 32'b0110);
    idle(1, 1'b0, '0, 0);

    n0 = n_avail;
    idle(20, 1'b1, 30'h0400_0010, 1);
    chk("miss_no_avail", 32'(n_avail - n0), 32'd0);

`ifdef ARILLA_TARGET_TIMEOUT_EN
    run_txn(1'b1, 1'b0, BASE_W + 30'd9, 32'h0, 4'hF, 1000, 32'h5555_AAAA, s0);
    chk("to_latency", 32'(last_avail_cyc - s0), 32'd16);
    chk("to_rdata", last_rdata, 32'hBADC_0FFE);
    n0 = n_avail;
    idle(1, 1'b0, '0, 0);
    idle(2, 1'b0, '0, 2);
    idle(2, 1'b0, '0, 0);
    chk("late_ack_no_avail", 32'(n_avail - n0), 32'd0);
    run_txn(1'b1, 1'b0, BASE_W + 30'd2, 32'h0, 4'hF, TC - 1, 32'h0BAD_CAFE, s0);
    chk("ack_at_expiry_rdata", last_rdata, 32'h0BAD_CAFE);
    idle(1, 1'b0, '0, 0);
`endif

    s0 = cyc;
    exp_q[s0]          = '0;
    exp_q[s0].icpt     = 1'b1;
    exp_q[s0 + 1]      = '0;
    exp_q[s0 + 1].icpt = 1'b1;
    exp_q[s0 + 1].req  = 1'b1;
    exp_q[s0 + 1].addr = 4'd7;
    exp_q[s0 + 1].be   = 4'hF;
    ack_delay = 1000;
    bus_address = BASE_W + 30'd7;
    bus_wdata = 32'h0;
    bus_byte_enable = 4'hF;
    bus_read = 1'b1;
    bus_write = 1'b0;
    next_cycle();
    next_cycle();
    exp_q[cyc] = '0;
    rst_n = 1'b0;
    bus_read = 1'b0;
    #1;
    chk("rst_mid_loc_req", 32'(loc_req), 32'h0);
    chk("rst_mid_loc_addr", 32'(loc_addr), 32'h0);
    next_cycle();
    exp_q[cyc] = '0;
    rst_n = 1'b1;
    next_cycle();
    run_txn(1'b1, 1'b0, BASE_W + 30'd1, 32'h0, 4'hF, 1, 32'h600D_D00D, s0);
    chk("post_rst_latency", 32'(last_avail_cyc - s0), 32'd3);
    chk("post_rst_rdata", last_rdata, 32'h600D_D00D);
    idle(1, 1'b0, '0, 0);

    n0 = n_avail;
    run_txn(1'b1, 1'b0, BASE_W + 30'd4, 32'h0, 4'hF, 1, 32'h1111_2222, s0);
    run_txn(1'b1, 1'b0, BASE_W + 30'd4, 32'h0, 4'hF, 1, 32'h1111_2222, s0);
    idle(3, 1'b0, '0, 0);
    chk("b2b_completions", 32'(n_avail - n0), 32'd2);

    for (int t = 0; t < 120; t++) begin
      int d;
      int gap;
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
`ifdef ARILLA_TARGET_TIMEOUT_EN
      d = $urandom_range(0, 19);
`else
      d = $urandom_range(0, 5);
`endif
      run_txn(rd, wr, BASE_W + 30'($urandom_range(0, 15)), $urandom, 4'($urandom), d, $urandom, s0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap, 1'($urandom_range(0, 1)), rand_miss(), 1);
    end
    idle(2, 1'b0, '0, 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
